// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing FSM for the RV32I core: fetch, decode, execute, memory, writeback.
// Traps on illegal opcodes and on instruction/data memory handshake timeouts.
//
// state  | meaning
// IDLE   | out of reset, all outputs quiet
// FETCH  | imem request held until ack, IR loaded on ack
// DECODE | latch op class, trap on illegal opcode/type
// EXEC   | ALU operand selects, branches retire here
// MEM    | data memory access for loads and stores, stores retire here
// WB     | register writeback and PC update, retire
// HALT   | parked at an instruction boundary while halt is requested
// TRAP   | sticky fault until reset

module multicycle_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       halt_req_i,
   output logic       imem_req_o,
   input  logic       imem_ack_i,
   output logic       ir_we_o,
   input  logic [6:0] op_dec_i,
   input  logic [5:0] type_dec_i,
   input  logic       branch_taken_i,
   output logic       dmem_req_o,
   output logic       dmem_we_o,
   input  logic       dmem_ack_i,
   output logic       pc_we_o,
   output logic [1:0] pc_sel_o,
   output logic       alu_a_sel_o,
   output logic       alu_b_sel_o,
   output logic       rf_we_o,
   output logic [1:0] wb_sel_o,
   output logic       instret_o,
   output logic [2:0] state_o,
   output logic       halted_o,
   output logic       trap_o,
   output logic [1:0] trap_cause_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_TRAP   = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      C_R      = 4'd0,
      C_OPIMM  = 4'd1,
      C_LOAD   = 4'd2,
      C_STORE  = 4'd3,
      C_BRANCH = 4'd4,
      C_JAL    = 4'd5,
      C_JALR   = 4'd6,
      C_LUI    = 4'd7,
      C_AUIPC  = 4'd8
   } cls_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state, state_nxt;
   cls_t             cls, cls_dec;
   logic             op_ok, type_ok, tmo, waiting;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       cause, cause_nxt;
   state_t           retire_nxt;

   always_comb begin
      op_ok   = 1'b1;
      cls_dec = C_R;
      case (op_dec_i)
         7'b0110011: cls_dec = C_R;
         7'b0010011: cls_dec = C_OPIMM;
         7'b0000011: cls_dec = C_LOAD;
         7'b0100011: cls_dec = C_STORE;
         7'b1100011: cls_dec = C_BRANCH;
         7'b1101111: cls_dec = C_JAL;
         7'b1100111: cls_dec = C_JALR;
         7'b0110111: cls_dec = C_LUI;
         7'b0010111: cls_dec = C_AUIPC;
         default:    op_ok   = 1'b0;
      endcase
   end

   // x & (x-1) clears the lowest set bit, so zero means at most one bit was set
   assign type_ok    = (type_dec_i != 6'd0) && ((type_dec_i & (type_dec_i - 6'd1)) == 6'd0);
   assign tmo        = (cnt == CNT_LAST);
   assign waiting    = ((state == S_FETCH) && !imem_ack_i) || ((state == S_MEM) && !dmem_ack_i);
   assign retire_nxt = halt_req_i ? S_HALT : S_FETCH;

   always_comb begin
      state_nxt   = state;
      cause_nxt   = cause;
      imem_req_o  = 1'b0;
      ir_we_o     = 1'b0;
      dmem_req_o  = 1'b0;
      dmem_we_o   = 1'b0;
      pc_we_o     = 1'b0;
      pc_sel_o    = 2'b00;
      alu_a_sel_o = 1'b0;
      alu_b_sel_o = 1'b0;
      rf_we_o     = 1'b0;
      wb_sel_o    = 2'b00;
      instret_o   = 1'b0;
      halted_o    = 1'b0;
      trap_o      = 1'b0;
      case (state)
         S_IDLE: state_nxt = halt_req_i ? S_HALT : S_FETCH;
         S_FETCH: begin
            imem_req_o = 1'b1;
            if (imem_ack_i) begin
               ir_we_o   = 1'b1;
               state_nxt = S_DECODE;
            end else if (tmo) begin
               state_nxt = S_TRAP;
               cause_nxt = 2'b10;
            end
         end
         S_DECODE: begin
            if (!op_ok || !type_ok) begin
               state_nxt = S_TRAP;
               cause_nxt = 2'b01;
            end else begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_a_sel_o = (cls == C_AUIPC);
            alu_b_sel_o = (cls == C_OPIMM) || (cls == C_LOAD) || (cls == C_STORE) ||
                          (cls == C_JALR)  || (cls == C_AUIPC);
            if (cls == C_BRANCH) begin
               pc_we_o   = 1'b1;
               pc_sel_o  = {1'b0, branch_taken_i};
               instret_o = 1'b1;
               state_nxt = retire_nxt;
            end else if ((cls == C_LOAD) || (cls == C_STORE)) begin
               state_nxt = S_MEM;
            end else begin
               state_nxt = S_WB;
            end
         end
         S_MEM: begin
            dmem_req_o  = 1'b1;
            dmem_we_o   = (cls == C_STORE);
            alu_b_sel_o = 1'b1;
            if (dmem_ack_i) begin
               if (cls == C_STORE) begin
                  pc_we_o   = 1'b1;
                  instret_o = 1'b1;
                  state_nxt = retire_nxt;
               end else begin
                  state_nxt = S_WB;
               end
            end else if (tmo) begin
               state_nxt = S_TRAP;
               cause_nxt = 2'b11;
            end
         end
         S_WB: begin
            rf_we_o   = 1'b1;
            pc_we_o   = 1'b1;
            instret_o = 1'b1;
            state_nxt = retire_nxt;
            case (cls)
               C_LOAD:  wb_sel_o = 2'b01;
               C_JAL:   begin wb_sel_o = 2'b10; pc_sel_o = 2'b01; end
               C_JALR:  begin wb_sel_o = 2'b10; pc_sel_o = 2'b10; end
               C_LUI:   wb_sel_o = 2'b11;
               default: wb_sel_o = 2'b00;
            endcase
         end
         S_HALT: begin
            halted_o = 1'b1;
            if (!halt_req_i) state_nxt = S_FETCH;
         end
         S_TRAP:  trap_o    = 1'b1;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         cls   <= C_R;
         cnt   <= '0;
         cause <= 2'b00;
      end else begin
         state <= state_nxt;
         cause <= cause_nxt;
         if (state == S_DECODE) cls <= cls_dec;
         if (state_nxt != state) cnt <= '0;
         else if (waiting)       cnt <= cnt + CNT_W'(1);
      end
   end

   assign state_o      = state;
   assign trap_cause_o = cause;

endmodule
